// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Single-outstanding-request instruction fetch unit. One word is fetched at a
// time from an instruction memory with a one-cycle acknowledge. The word is
// presented to the decoder together with its address, held while the decoder
// stalls, and the PC then advances by 4 or follows a branch/jump redirect.
// A redirect that arrives while a memory request is still outstanding is
// remembered and applied once that request has been acknowledged. A redirect
// to a target that is not word-aligned parks the unit in a trap state until
// an aligned redirect arrives.
//
// Parameters
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   imem_req     instruction memory read request
//   imem_addr    word-aligned fetch address, stable while imem_req is high
//   imem_ack     one-cycle acknowledge, imem_rdata valid in the same cycle
//   imem_rdata   fetched instruction word
//   redirect     one-cycle PC change request from branch/jump resolution
//   redirect_pc  redirect target, sampled when redirect is high
//   stall        decoder busy: hold the presented instruction
//   instr        instruction word for the decoder
//   instr_pc     address of instr
//   instr_valid  instr/instr_pc are valid
//   misaligned   last redirect target was not word-aligned (trap state)
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misaligned
);

  // State encoding
  localparam logic [1:0] ST_FETCH = 2'd0;  // request outstanding at pc
  localparam logic [1:0] ST_VALID = 2'd1;  // word presented to the decoder
  localparam logic [1:0] ST_DRAIN = 2'd2;  // stale request outstanding
  localparam logic [1:0] ST_TRAP  = 2'd3;  // misaligned redirect target

  // Canonical RISC-V NOP (addi x0, x0, 0) shown while nothing is fetched yet
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic [31:0] pending_reg, pending_next;

  logic [31:0] pc_plus4;
  logic        redirect_bad;
  logic [31:0] drain_target;
  logic        drain_target_bad;

  // 32-bit addition wraps naturally from 0xFFFF_FFFC to 0.
  assign pc_plus4     = pc_reg + 32'd4;
  assign redirect_bad = |redirect_pc[1:0];

  // While draining, the most recent redirect wins: a redirect in the very
  // cycle the stale data comes back is applied directly.
  assign drain_target     = redirect ? redirect_pc : pending_reg;
  assign drain_target_bad = |drain_target[1:0];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    pending_next  = pending_reg;

    case (state_reg)
      ST_FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            // Data for the old pc arrives with the redirect: drop it and
            // move straight on (the request is complete, nothing to drain).
            if (redirect_bad) begin
              state_next = ST_TRAP;
            end else begin
              pc_next    = redirect_pc;
              state_next = ST_FETCH;
            end
          end else begin
            // Request still in flight: keep the address stable and wait for
            // its acknowledge before switching to the new target.
            pending_next = redirect_pc;
            state_next   = ST_DRAIN;
          end
        end else if (imem_ack) begin
          instr_next    = imem_rdata;
          instr_pc_next = pc_reg;
          state_next    = ST_VALID;
        end
      end

      ST_VALID: begin
        // Redirect has priority over stall; imem_ack is ignored here.
        if (redirect) begin
          if (redirect_bad) begin
            state_next = ST_TRAP;
          end else begin
            pc_next    = redirect_pc;
            state_next = ST_FETCH;
          end
        end else if (!stall) begin
          pc_next    = pc_plus4;
          state_next = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (redirect) begin
          pending_next = redirect_pc;
        end
        if (imem_ack) begin
          // Returned word belongs to the abandoned path and is discarded.
          if (drain_target_bad) begin
            state_next = ST_TRAP;
          end else begin
            pc_next    = drain_target;
            state_next = ST_FETCH;
          end
        end
      end

      ST_TRAP: begin
        // Only an aligned redirect leaves the trap; imem_ack is ignored.
        if (redirect && !redirect_bad) begin
          pc_next    = redirect_pc;
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= RESET_PC;
      instr_reg    <= NOP_INSTR;
      instr_pc_reg <= RESET_PC;
      pending_reg  <= 32'h0000_0000;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      pending_reg  <= pending_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The request is gated by rst_n so it is low for the whole reset period and
  // rises in the very first cycle with rst_n high (state is already FETCH).
  assign imem_req    = rst_n && ((state_reg == ST_FETCH) || (state_reg == ST_DRAIN));
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = (state_reg == ST_VALID);
  assign misaligned  = (state_reg == ST_TRAP);

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. A memory process answers requests (zero-wait or
// random latency, optional stray acknowledges). A transaction-level model
// tracks which address must be delivered next: the latest aligned redirect
// target, otherwise the successor (pc+4) of the last consumed instruction.
// Expected addresses are queued; a monitor pops one each time instr_valid
// rises and checks address and data. Directed sequences come first, then a
// randomized run.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misaligned;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .misaligned  (misaligned)
  );

  int errors = 0;
  int checks = 0;

  // memory behaviour controls
  logic [31:0] mem_xor   = 32'h0;
  bit          mem_hold  = 1'b0;
  bit          mem_rand  = 1'b0;
  bit          force_ack = 1'b0;
  bit          stray_en  = 1'b0;

  // reference model / scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc = 32'h0;
  bit          model_trap = 1'b0;
  int          since = 0;

  // monitor history
  bit          mon_valid = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_addr = 32'h0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  bit          prev_rst = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a, input logic [31:0] x);
    return (a == 32'h10) ? 32'h0050_0093 : (a ^ x);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] pc);
    int n = 0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && instr_pc === pc) return;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL wait_valid: pc %h never presented, last instr_pc %h", pc, instr_pc);
        return;
      end
    end
  endtask

  // Instruction memory: answers at #2 after the edge so bench inputs set at
  // #1 (rst_n) are already reflected in imem_req.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (force_ack) begin
        imem_ack = 1'b1;
      end else if (imem_req && !mem_hold) begin
        if (!mem_rand || ($urandom % 3 == 0)) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_data(imem_addr, mem_xor);
        end
      end else if (!imem_req && stray_en && ($urandom % 4 == 0)) begin
        imem_ack = 1'b1;
      end
    end
  end

  // Reference model: updated at each edge from the inputs of the cycle that
  // just ended and the valid flag the monitor saw in that cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_q.push_back(RST_PC);
        model_trap = 1'b0;
        since = 0;
      end else if (redirect) begin
        exp_q.delete();
        since = 0;
        if (redirect_pc[1:0] == 2'b00) begin
          exp_q.push_back(redirect_pc);
          model_trap = 1'b0;
        end else begin
          model_trap = 1'b1;
        end
      end else if (mon_valid && !stall) begin
        exp_q.push_back(cur_pc + 32'd4);
        since = 0;
      end else begin
        since++;
      end
    end
  end

  // Monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1)
        check32("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
      if (prev_req && !prev_ack && prev_rst && rst_n) begin
        check1("req_held", imem_req, 1'b1);
        check32("addr_stable", imem_addr, prev_addr);
      end
      if (instr_valid === 1'b1 && !mon_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got instr_pc %h, none expected", instr_pc);
        end else begin
          e = exp_q.pop_front();
          cur_pc = e;
          check32("sb_instr_pc", instr_pc, e);
          check32("sb_instr", instr, mem_data(e, mem_xor));
        end
      end
      if (instr_valid === 1'b1 && mon_valid) begin
        check32("hold_instr", instr, prev_instr);
        check32("hold_instr_pc", instr_pc, prev_pc);
      end
      if (misaligned === 1'b1) begin
        check1("trap_expected", model_trap, 1'b1);
        check1("trap_req_low", imem_req, 1'b0);
        check1("trap_valid_low", instr_valid, 1'b0);
      end
      if (since > 40) begin
        checks++;
        if (exp_q.size() != 0 || (model_trap && misaligned !== 1'b1)) begin
          errors++;
          $display("FAIL watchdog: no progress, queued=%0d trap=%0b misaligned=%b",
                   exp_q.size(), model_trap, misaligned);
        end
        since = 0;
      end
      mon_valid  = (instr_valid === 1'b1);
      prev_instr = instr;
      prev_pc    = instr_pc;
      prev_addr  = imem_addr;
      prev_req   = (imem_req === 1'b1);
      prev_ack   = (imem_ack === 1'b1);
      prev_rst   = rst_n;
    end
  end

  // Stimulus
  initial begin
    int r;
    // ---- reset values ----
    repeat (3) tick();
    @(negedge clk);
    check1("rst_imem_req", imem_req, 1'b0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check1("rst_misaligned", misaligned, 1'b0);
    check32("rst_instr", instr, NOP);
    check32("rst_instr_pc", instr_pc, RST_PC);
    $display("reset: req=%b valid=%b instr=%h pc=%h", imem_req, instr_valid, instr, instr_pc);

    // ---- sequential fetch, zero-wait, addr-as-data ----
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, RST_PC);
      end
      check1("seq_valid", instr_valid, (k % 2) == 1);
      if (k % 2 == 1) begin
        check32("seq_pc", instr_pc, RST_PC + 32'((k - 1) / 2 * 4));
        check32("seq_data", instr, RST_PC + 32'((k - 1) / 2 * 4));
      end
      $display("seq cycle %0d: valid=%b pc=%h instr=%h", k, instr_valid, instr_pc, instr);
      tick();
    end

    // ---- stall holds 0x10 for 5 cycles ----
    stall = 1'b1;
    wait_valid(32'h10);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      check1("stall_valid", instr_valid, 1'b1);
      check32("stall_instr", instr, 32'h0050_0093);
      check32("stall_pc", instr_pc, 32'h10);
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    check1("stall_release_valid", instr_valid, 1'b1);
    tick();
    @(negedge clk);
    check32("after_stall_addr", imem_addr, 32'h14);
    $display("stall: released, next fetch addr=%h", imem_addr);

    // ---- redirect in VALID while stalled ----
    tick();
    stall = 1'b1;
    @(negedge clk);
    check32("valid_0x14", instr_pc, 32'h14);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    mem_hold = 1'b1;
    @(negedge clk);
    check1("redir_valid_req", imem_req, 1'b1);
    check32("redir_valid_addr", imem_addr, 32'h100);
    $display("redirect in VALID: addr=%h", imem_addr);

    // ---- redirect in FETCH, ack 3 cycles later ----
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check32("drain_addr", imem_addr, 32'h100);
    tick();
    @(negedge clk);
    check1("drain_valid", instr_valid, 1'b0);
    tick();
    mem_hold = 1'b0;
    @(negedge clk);
    check1("drain_ack_valid", instr_valid, 1'b0);
    tick();
    stall = 1'b1;
    @(negedge clk);
    check32("post_drain_addr", imem_addr, 32'h200);
    check1("post_drain_valid", instr_valid, 1'b0);
    $display("redirect in FETCH: dropped, addr=%h", imem_addr);
    tick();
    @(negedge clk);
    check32("valid_0x200", instr_pc, 32'h200);

    // ---- misaligned redirect, trap, recovery ----
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    stall = 1'b0;
    @(negedge clk);
    tick();
    redirect = 1'b0;
    stray_en = 1'b1;
    @(negedge clk);
    check1("trap_misaligned", misaligned, 1'b1);
    check1("trap_req", imem_req, 1'b0);
    repeat (3) begin
      tick();
      @(negedge clk);
      check1("trap_stays", misaligned, 1'b1);
    end
    tick();
    stray_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    tick();
    redirect = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    check1("untrap_misaligned", misaligned, 1'b0);
    check32("untrap_addr", imem_addr, 32'h300);
    $display("trap: left, addr=%h", imem_addr);

    // ---- wrap of pc+4 ----
    tick();
    @(negedge clk);
    check32("valid_0x300", instr_pc, 32'h300);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    stall = 1'b0;
    @(negedge clk);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check32("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check32("top_valid_pc", instr_pc, 32'hFFFF_FFFC);
    tick();
    mem_hold = 1'b1;
    @(negedge clk);
    check32("wrap_addr", imem_addr, 32'h0);
    $display("wrap: addr=%h", imem_addr);

    // ---- reset while draining ----
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check32("drain2_addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check1("rst_drain_req", imem_req, 1'b0);
    tick();
    force_ack = 1'b1;
    @(negedge clk);
    tick();
    force_ack = 1'b0;
    mem_hold = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check1("restart_req", imem_req, 1'b1);
    check32("restart_addr", imem_addr, RST_PC);
    tick();
    @(negedge clk);
    check32("restart_valid_pc", instr_pc, RST_PC);
    $display("reset in DRAIN: restart addr=%h", RST_PC);

    // ---- randomized run ----
    tick();
    rst_n = 1'b0;
    mem_xor = 32'hC3A5_5A3C;
    mem_rand = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      stray_en = 1'b1;
      stall = ($urandom % 4 == 0);
      rst_n = ($urandom % 400 != 0);
      redirect = ($urandom % 12 == 0);
      if (redirect) begin
        r = $urandom_range(0, 255);
        case ($urandom % 8)
          0: redirect_pc = 32'hFFFF_FFF8;
          1: redirect_pc = (32'(r) << 2) | 32'($urandom_range(1, 3));
          default: redirect_pc = 32'(r) << 2;
        endcase
      end
    end
    tick();
    rst_n = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    stray_en = 1'b0;
    mem_rand = 1'b0;
    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 imem_req  output  1  SHALL be the instruction memory read request.
REQ-005 imem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-006 imem_ack  input  1  SHALL be a one-cycle pulse; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-008 redirect  input  1  SHALL request a PC change from branch/jump resolution (one-cycle pulse).
REQ-009 redirect_pc  input  32  SHALL be the target address, sampled when redirect=1.
REQ-010 stall  input  1  SHALL hold the current instruction while the downstream decoder is busy.
REQ-011 instr  output  32  SHALL carry the fetched word to the instruction decoder.
REQ-012 instr_pc  output  32  SHALL carry the address of instr.
REQ-013 instr_valid  output  1  SHALL mark instr/instr_pc as valid.
REQ-014 misaligned  output  1  SHALL flag a redirect target with bits[1:0] != 0.

Function
REQ-015 States SHALL be FETCH, VALID, DRAIN, TRAP, encoded in at most 2 bits.
REQ-016 FETCH: imem_req=1, imem_addr=pc.
- imem_ack and no redirect: capture instr=imem_rdata and instr_pc=pc, go to VALID.
REQ-017 VALID: instr_valid=1, imem_req=0.
- redirect=1: go to FETCH with pc=redirect_pc; redirect takes priority over stall.
- redirect=0, stall=0: go to FETCH with pc=pc+4.
- stall=1: hold; instr and instr_pc stay unchanged.
REQ-018 Fetch latency SHALL be: imem_ack in cycle N gives instr_valid=1 in cycle N+1; minimum spacing between valid instructions is 2 cycles with zero-wait memory.
REQ-019 Redirect in FETCH without imem_ack:
- save redirect_pc in a pending register;
- go to DRAIN;
- keep imem_req=1 and imem_addr unchanged (the old pc).
REQ-020 DRAIN: on imem_ack, discard imem_rdata, load pc=pending target, go to FETCH; a new redirect in DRAIN overwrites the pending target.
REQ-021 Redirect in FETCH in the same cycle as imem_ack: discard the data, load pc=redirect_pc, go to FETCH; instr_valid stays 0.
REQ-022 While imem_req=1, imem_addr SHALL stay constant until the imem_ack cycle.
REQ-023 A redirect with redirect_pc[1:0] != 0 SHALL lead to TRAP, either directly or after the DRAIN completes.
- TRAP: misaligned=1, imem_req=0, instr_valid=0.
- An aligned redirect leaves TRAP to FETCH at that target.
- A misaligned redirect keeps TRAP.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 instr_valid SHALL be 0 in FETCH, DRAIN and TRAP.
REQ-026 imem_ack outside FETCH/DRAIN SHALL be ignored.

Reset
REQ-027 With rst_n=0 at a clock edge, the block SHALL set:
- state=FETCH, pc=RESET_PC;
- instr=32'h0000_0013 (NOP), instr_pc=RESET_PC;
- instr_valid=0, misaligned=0, pending target=0.
REQ-028 During reset imem_req SHALL be 0; imem_req SHALL rise in the first cycle after rst_n=1.
REQ-029 Reset in any state, including DRAIN with an outstanding request, SHALL abandon the request; a later stray imem_ack is ignored by REQ-026 only if it arrives while rst_n=0.

Verification
REQ-030 Reset release, zero-wait memory returning addr-as-data -> instr_pc sequence 0,4,8,... with instr_valid high every second cycle.
REQ-031 stall=1 for 5 cycles in VALID with instr=32'h00500093 -> instr, instr_pc and instr_valid held; then pc+4 fetched.
REQ-032 redirect to 32'h100 in VALID with stall=1 -> next imem_addr=32'h100.
REQ-033 redirect to 32'h200 in FETCH, imem_ack 3 cycles later -> that data is dropped, instr_valid stays 0, next imem_addr=32'h200.
REQ-034 redirect to 32'h102 -> misaligned=1 and imem_req=0; then redirect to 32'h300 -> misaligned=0 and fetch at 32'h300.
REQ-035 pc=32'hFFFF_FFFC, no stall -> next imem_addr=32'h0000_0000; rst_n=0 in DRAIN -> restart at RESET_PC.
